// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scanout engine and the pixel store.
// The scanout side issues addresses; the store returns data one cycle later.
interface vga_scanout_if #(
   parameter int BITS_PER_PIXEL = 3
);
   logic [31:0]               read_addr;
   logic [BITS_PER_PIXEL-1:0] read_data;

   modport master (output read_addr, input read_data);
   modport slave  (input read_addr, output read_data);
endinterface

// File: rtl/vga_scanout.sv
// VGA raster timing plus framebuffer scanout with a frame-latched buffer select.
// Pixel, sync and active outputs leave through a common 3-stage delay.
module vga_scanout #(
   parameter int BITS_PER_PIXEL    = 3,
   parameter int FRAMEBUFFER_DEPTH = 640*480,
   parameter int H_ACTIVE          = 640,
   parameter int H_FRONT           = 16,
   parameter int H_SYNC            = 96,
   parameter int H_BACK            = 48,
   parameter int V_ACTIVE          = 480,
   parameter int V_FRONT           = 10,
   parameter int V_SYNC            = 2,
   parameter int V_BACK            = 33,
   parameter int SYNC_ACTIVE_LOW   = 1
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset_N,
   input  logic                      i_Buffer_Select,
   vga_scanout_if.master             fb,
   output logic [BITS_PER_PIXEL-1:0] o_Pixel,
   output logic                      o_HSync,
   output logic                      o_VSync,
   output logic                      o_Active,
   output logic                      o_Frame_Start,
   output logic                      o_Displayed_Buffer
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

   localparam logic [31:0] BASE1    = 32'(FRAMEBUFFER_DEPTH);
   localparam logic        SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic        SYNC_OFF = ~SYNC_ON;

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          origin;
   logic          active;
   logic          hs;
   logic          vs;
   logic          sel_now;
   logic [31:0]   index;
   logic [31:0]   index_now;
   logic [1:0]    act_d;
   logic [1:0]    hs_d;
   logic [1:0]    vs_d;

   // Stage-0 decode; at the frame origin the select and index take effect
   // in the same cycle as the first pixel read.
   always_comb begin
      origin    = (h == '0) && (v == '0);
      active    = (h < H_VIS) && (v < V_VIS);
      hs        = (h >= HS_BEG) && (h < HS_END);
      vs        = (v >= VS_BEG) && (v < VS_END);
      sel_now   = origin ? i_Buffer_Select : o_Displayed_Buffer;
      index_now = origin ? '0 : index;
   end

   // Raster counters: h wraps every line, v steps on each h wrap.
   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   // Frame pulse, buffer latch and running read address (held in blanking).
   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         o_Frame_Start      <= 1'b0;
         o_Displayed_Buffer <= 1'b0;
         fb.read_addr       <= '0;
         index              <= '0;
      end else begin
         o_Frame_Start <= origin;
         if (origin)
            o_Displayed_Buffer <= i_Buffer_Select;
         if (active) begin
            fb.read_addr <= (sel_now ? BASE1 : '0) + index_now;
            index        <= index_now + 32'd1;
         end
      end
   end

   // Delay the decodes to meet the returning read data, then register outputs.
   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         act_d    <= '0;
         hs_d     <= '0;
         vs_d     <= '0;
         o_Active <= 1'b0;
         o_Pixel  <= '0;
         o_HSync  <= SYNC_OFF;
         o_VSync  <= SYNC_OFF;
      end else begin
         act_d    <= {act_d[0], active};
         hs_d     <= {hs_d[0], hs};
         vs_d     <= {vs_d[0], vs};
         o_Active <= act_d[1];
         o_Pixel  <= act_d[1] ? fb.read_data : '0;
         o_HSync  <= hs_d[1] ? SYNC_ON : SYNC_OFF;
         o_VSync  <= vs_d[1] ? SYNC_ON : SYNC_OFF;
      end
   end

endmodule
